shift_engine_param: RTL and testbench

SHIFT_ENGINE_PARAM -- requirements
Module: shift_engine_param

---
 rtl/shift_engine_param.sv | 126 ++++++++++++
 tb/tb_shift_engine_param.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_engine_param.sv
// shift_engine_param: multi-mode shift register engine.
// A command (mode, amount, data_in) is accepted on start while idle. Loads,
// holds and zero-length shifts finish at the accepting edge. Real shifts
// then step one bit per clock for `amount` cycles, and done pulses on the
// last step.
module shift_engine_param #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] amount,
    input  logic [WIDTH-1:0] data_in,
    input  logic             serial_in,
    output logic [WIDTH-1:0] data_out,
    output logic             serial_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef enum logic [2:0] {
        M_HOLD = 3'b000,
        M_ASR  = 3'b001,
        M_LSL  = 3'b010,
        M_LOAD = 3'b011,
        M_LSR  = 3'b100,
        M_ROR  = 3'b101,
        M_ROL  = 3'b110,
        M_SLI  = 3'b111
    } mode_e;

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             sout_q, sout_d;
    logic             done_q, done_d;

    // One 1-bit step of mode m. The result is {bit that left, new value}.
    // For rotates, the bit that left is the same bit that wrapped around.
    function automatic logic [WIDTH:0] shift_step(
        input mode_e            m,
        input logic [WIDTH-1:0] v,
        input logic             si,
        input logic             so
    );
        case (m)
            M_ASR:   shift_step = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
            M_LSL:   shift_step = {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
            M_LSR:   shift_step = {v[0], 1'b0, v[WIDTH-1:1]};
            M_ROR:   shift_step = {v[0], v[0], v[WIDTH-1:1]};
            M_ROL:   shift_step = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
            M_SLI:   shift_step = {v[WIDTH-1], v[WIDTH-2:0], si};
            default: shift_step = {so, v};
        endcase
    endfunction

    // Next-state logic: command acceptance in IDLE, single-bit stepping in RUN.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
        state_d = state_q;
        mode_d  = mode_q;
        count_d = count_q;
        data_d  = data_q;
        sout_d  = sout_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (mode_e'(mode) == M_LOAD) begin
                        data_d = data_in;
                        done_d = 1'b1;
                    end else if (mode_e'(mode) == M_HOLD || amount == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                        mode_d  = mode_e'(mode);
                        count_d = amount;
                    end
                end
            end
            RUN: begin
                {sout_d, data_d} = shift_step(mode_q, data_q, serial_in, sout_q);
                count_d = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register. A synchronous reset clears everything and aborts any shift in progress.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so all registers update together from pre-edge values.
        if (reset) begin
            state_q <= IDLE;
            mode_q  <= M_HOLD;
            count_q <= '0;
            data_q  <= '0;
            sout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            count_q <= count_d;
            data_q  <= data_d;
            sout_q  <= sout_d;
            done_q  <= done_d;
        end
    end

    assign data_out   = data_q;
    assign serial_out = sout_q;
    assign busy       = (state_q == RUN);
    assign done       = done_q;

endmodule

// File: tb/tb_shift_engine_param.sv
// Testbench for shift_engine_param (WIDTH=8, CNT_W=4).
// The stimulus side computes each command's outcome with a whole-shift
// arithmetic model and queues it. The monitor pops an entry on every done
// pulse and checks the data, the serial bit and the completion cycle.
module tb_shift_engine_param;

    localparam int W = 8;
    localparam int C = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   mode;
    logic [C-1:0] amount;
    logic [W-1:0] data_in;
    logic         serial_in;
    logic [W-1:0] data_out;
    logic         serial_out;
    logic         busy;
    logic         done;

    typedef struct {
        logic [W-1:0] data;
        logic         sout;
        int           due;
    } exp_t;

    exp_t         sb[$];
    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    logic [W-1:0] cur_data;
    logic         cur_sout;

    shift_engine_param #(.WIDTH(W), .CNT_W(C)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mode       (mode),
        .amount     (amount),
        .data_in    (data_in),
        .serial_in  (serial_in),
        .data_out   (data_out),
        .serial_out (serial_out),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Count rising edges; at a falling edge this equals the number of edges so far.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Outcome of an n-step shift of v, computed as one arithmetic operation.
    // Returns {last bit out, result}. bits[k] is the fill bit of step k.
    function automatic logic [W:0] model(input logic [2:0] m, input int n,
                                         input logic [W-1:0] v, input logic [15:0] bits);
        logic [127:0]        big;
        logic [127:0]        prev;
        logic [127:0]        fb;
        logic signed [127:0] s;
        logic [2*W-1:0]      dbl;
        logic [2*W-1:0]      rot;
        int                  k;
        k   = n % W;
        dbl = {v, v};
        fb  = '0;
        case (m)
            3'b001: begin
                s    = signed'({{(128-W){v[W-1]}}, v});
                big  = s >>> n;
                prev = s >>> (n - 1);
                model = {prev[0], big[W-1:0]};
            end
            3'b100: begin
                big  = 128'(v) >> n;
                prev = 128'(v) >> (n - 1);
                model = {prev[0], big[W-1:0]};
            end
            3'b010: begin
                big   = 128'(v) << n;
                model = {big[W], big[W-1:0]};
            end
            3'b111: begin
                for (int i = 0; i < n; i++) fb[n-1-i] = bits[i];
                big   = (128'(v) << n) | fb;
                model = {big[W], big[W-1:0]};
            end
            3'b101: begin
                rot   = dbl >> k;
                model = {rot[W-1], rot[W-1:0]};
            end
            3'b110: begin
                rot   = dbl << k;
                model = {rot[W], rot[2*W-1:W]};
            end
            default: model = {1'b0, v};
        endcase
    endfunction

    // Issue one command starting at a falling edge. The task returns at the
    // falling edge of the done cycle, so a following call starts back-to-back.
    // With noise set, start/mode/amount/data_in are scrambled during RUN.
    task automatic issue(input logic [2:0] m, input int n, input logic [W-1:0] din,
                         input logic [15:0] bits, input bit noise);
        int       e;
        bit       shifting;
        logic [W:0] r;
        e        = cyc;
        shifting = (m != 3'b011) && (m != 3'b000) && (n != 0);
        start    = 1'b1;
        mode     = m;
        amount   = C'(n);
        data_in  = din;
        serial_in = 1'($urandom);
        if (m == 3'b011) begin
            cur_data = din;
        end else if (shifting) begin
            r        = model(m, n, cur_data, bits);
            cur_sout = r[W];
            cur_data = r[W-1:0];
        end
        sb.push_back('{data: cur_data, sout: cur_sout, due: shifting ? e + 1 + n : e + 1});
        @(negedge clk);
        start = 1'b0;
        if (shifting) begin
            for (int i = 0; i < n; i++) begin
                check("busy_run", busy, 1);
                serial_in = bits[i];
                if (noise) begin
                    start   = 1'($urandom);
                    mode    = 3'($urandom);
                    amount  = C'($urandom);
                    data_in = W'($urandom);
                end
                @(negedge clk);
            end
            start = 1'b0;
        end
        check("busy_idle", busy, 0);
        check("done_high", done, 1);
    endtask

    // Monitor: each done pulse must match the oldest expected command.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done=1 expected no pending command (t=%0t)", $time);
                end else begin
                    x = sb.pop_front();
                    check("sb_data", data_out, x.data);
                    check("sb_sout", serial_out, x.sout);
                    check("sb_cycle", cyc, x.due);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1);
    end

    initial begin
        logic [2:0] zm[7];
        zm = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b110, 3'b111};
        reset     = 1'b1;
        start     = 1'b0;
        mode      = '0;
        amount    = '0;
        data_in   = '0;
        serial_in = 1'b0;
        cur_data  = '0;
        cur_sout  = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_data", data_out, 0);
        check("rst_sout", serial_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);

        // Load then arithmetic right by 2, with start pulses during RUN.
        issue(3'b011, 0, 8'h96, 16'h0, 1'b0);
        check("load_96", data_out, 8'h96);
        issue(3'b001, 2, 8'h00, 16'h0, 1'b1);
        check("asr_data", data_out, 8'hE5);
        check("asr_sout", serial_out, 1);

        // Rotate left by 3 from 0x96.
        issue(3'b011, 0, 8'h96, 16'h0, 1'b0);
        issue(3'b110, 3, 8'h00, 16'h0, 1'b0);
        check("rol_data", data_out, 8'hB4);

        // Shift longer than the width saturates to zeros.
        issue(3'b011, 0, 8'hFF, 16'h0, 1'b0);
        issue(3'b010, 9, 8'h00, 16'h0, 1'b1);
        check("lsl9_data", data_out, 8'h00);
        check("lsl9_sout", serial_out, 0);

        // Serial fill of 1,0,1,1.
        issue(3'b011, 0, 8'h00, 16'h0, 1'b0);
        issue(3'b111, 4, 8'h00, 16'b1101, 1'b0);
        check("sli_data", data_out, 8'h0B);

        // A zero amount completes at once and leaves the data unchanged.
        foreach (zm[i]) begin
            issue(zm[i], 0, W'($urandom), 16'h0, 1'b0);
            check("zero_amt_data", data_out, 8'h0B);
        end

        // Reset after two steps of a 5-step right shift: no done pulse.
        start   = 1'b1;
        mode    = 3'b100;
        amount  = 4'd5;
        data_in = 8'h5A;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_busy", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cur_data = '0;
        cur_sout = 1'b0;
        check("abort_data", data_out, 0);
        check("abort_sout", serial_out, 0);
        check("abort_busy0", busy, 0);
        check("abort_done", done, 0);
        repeat (8) @(negedge clk);
        check("abort_idle", busy, 0);

        // Random commands, mostly back-to-back, some with idle gaps.
        for (int t = 0; t < 120; t++) begin
            int n;
            n = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 15));
            issue(3'($urandom), n, W'($urandom), 16'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                start = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end

        start = 1'b0;
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
